// File: rtl/uart_pkg.sv
// Shared UART receiver types: parity selection, receiver FSM states and the
// standard bit period for a 50 MHz clock at 19200 baud.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int BAUD_50M_19200 = 2604;

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// Show-ahead receive FIFO: the head word is always visible on rd_data while
// not empty. Storage is not reset; only the pointers are.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             rd_ok, wr_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A same-cycle pop frees the slot a push into a full FIFO needs.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign rd_data = mem[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (rd_ok) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with start-glitch rejection, framing/parity/overrun flags and
// a show-ahead receive FIFO popped by the command processor.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int      CLKS_PER_BIT = BAUD_50M_19200,
  parameter int      DATA_BITS    = 8,
  parameter parity_t PARITY       = PAR_NONE,
  parameter int      FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frm_err,
  output logic                 par_err,
  output logic                 ovr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  // Loaded values count remaining cycles including the sample cycle itself,
  // so successive samples are exactly CLKS_PER_BIT cycles apart.
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_sync_q;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;
  logic                 pend_perr_q, pend_perr_d;
  logic                 frm_err_q, par_err_q, ovr_q;
  logic                 sample, push, frm_set, par_set, ovr_set;
  logic                 fifo_full, fifo_empty;

  assign sample = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    par_acc_d   = par_acc_q;
    pend_perr_d = pend_perr_q;
    push        = 1'b0;
    frm_set     = 1'b0;
    par_set     = 1'b0;

    if (state_q != IDLE && state_q != BREAK) cnt_d = sample ? BIT_LOAD : cnt_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d     = START;
          cnt_d       = HALF_LOAD;
          bitcnt_d    = '0;
          par_acc_d   = 1'b0;
          pend_perr_d = 1'b0;
        end
      end
      START: begin
        if (sample) state_d = rx_sync_q ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_d   = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          par_acc_d = par_acc_q ^ rx_sync_q;
          bitcnt_d  = bitcnt_q + 1'b1;
          if (bitcnt_q == LAST_BIT) state_d = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
        end
      end
      uart_pkg::PARITY: begin
        if (sample) begin
          if ((par_acc_q ^ rx_sync_q) != (PARITY == PAR_ODD)) begin
            pend_perr_d = 1'b1;
            par_set     = 1'b1;
          end
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          if (rx_sync_q) begin
            push    = !pend_perr_q;
            state_d = IDLE;
          end else begin
            frm_set = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle makes room, so only an unserved full FIFO drops.
  assign ovr_set = push && fifo_full && !(rd_en && rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_acc_q   <= 1'b0;
      pend_perr_q <= 1'b0;
      frm_err_q   <= 1'b0;
      par_err_q   <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      rx_meta_q   <= RX;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_acc_q   <= par_acc_d;
      pend_perr_q <= pend_perr_d;
      frm_err_q   <= frm_set | (frm_err_q & ~clr_err);
      par_err_q   <= par_set | (par_err_q & ~clr_err);
      ovr_q       <= ovr_set | (ovr_q & ~clr_err);
    end
  end

  rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (shift_q),
    .rd_en   (rd_en),
    .rd_data (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rdy     = !fifo_empty;
  assign frm_err = frm_err_q;
  assign par_err = par_err_q;
  assign ovr     = ovr_q;

endmodule
